// File: rtl/rv32i_types.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rv32i_types : shared RV32I pipeline types (control word)          |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
package rv32i_types;

    typedef struct packed {
        logic [6:0] opcode;
        logic [3:0] aluop;
        logic [2:0] funct3;
        logic       regfile_ld;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] regfile_mux_sel;
    } rv32i_control_word;

endpackage
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_stage : EX/MEM latch, data-memory handshake, load alignment   |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
module mem_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              flush,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       rs2_in,
    input  logic [31:0]       pc_plus4_in,
    input  logic [31:0]       u_imm_in,
    input  logic [31:0]       ir_in,
    input  logic [4:0]        rd_addr_in,
    input  rv32i_control_word control_rom_in,
    input  logic              data_resp,
    input  logic [31:0]       data_rdata,
    output logic              data_read,
    output logic              data_write,
    output logic [3:0]        data_mbe,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    output logic              mem_stall,
    output logic [31:0]       MEM_alu_out,
    output logic [31:0]       pc_plus4_out,
    output logic [31:0]       u_imm_out,
    output logic [31:0]       ir_out,
    output logic [4:0]        rd_addr_out,
    output rv32i_control_word control_rom_out,
    output logic [31:0]       mem_rdata
);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_alu;
    logic [31:0]       r_rs2;
    logic [31:0]       r_pc_plus4;
    logic [31:0]       r_u_imm;
    logic [31:0]       r_ir;
    logic [4:0]        r_rd;
    rv32i_control_word r_ctrl;
    logic [31:0]       r_rdata_q;

    logic              w_busy;
    logic              w_resp;
    logic              w_new_mem;
    logic [1:0]        w_off;
    logic [2:0]        w_f3;
    logic [3:0]        w_mbe;
    logic [31:0]       w_raw;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // EX/MEM latch; a flushed slot keeps its data but carries no control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu      <= '0;
            r_rs2      <= '0;
            r_pc_plus4 <= '0;
            r_u_imm    <= '0;
            r_ir       <= '0;
            r_rd       <= '0;
            r_ctrl     <= '0;
        end else if (load) begin
            r_alu      <= alu_in;
            r_rs2      <= rs2_in;
            r_pc_plus4 <= pc_plus4_in;
            r_u_imm    <= u_imm_in;
            r_rd       <= rd_addr_in;
            r_ir       <= flush ? '0 : ir_in;
            r_ctrl     <= flush ? '0 : control_rom_in;
        end
    end

    assign w_busy    = (r_state == S_BUSY);
    assign w_resp    = w_busy & data_resp;
    assign w_new_mem = ~flush & (control_rom_in.mem_read | control_rom_in.mem_write);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // a new instruction latched on the response edge overrides DONE
    always_comb begin
        w_state_next = r_state;
        data_read    = 1'b0;
        data_write   = 1'b0;
        mem_stall    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (load) begin
                    w_state_next = w_new_mem ? S_BUSY : S_IDLE;
                end
            end
            S_BUSY: begin
                data_read  = r_ctrl.mem_read;
                data_write = r_ctrl.mem_write;
                mem_stall  = ~data_resp;
                if (load) begin
                    w_state_next = w_new_mem ? S_BUSY : S_IDLE;
                end else if (data_resp) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata_q <= '0;
        end else if (w_resp) begin
            r_rdata_q <= data_rdata;
        end
    end

    assign w_off = r_alu[1:0];
    assign w_f3  = r_ctrl.funct3;

    always_comb begin
        w_mbe      = 4'b0000;
        data_wdata = r_rs2;
        case (w_f3)
            c_F3_B: begin
                w_mbe      = 4'b0001 << w_off;
                data_wdata = {4{r_rs2[7:0]}};
            end
            c_F3_H: begin
                w_mbe      = 4'b0011 << {w_off[1], 1'b0};
                data_wdata = {2{r_rs2[15:0]}};
            end
            c_F3_W: w_mbe = 4'b1111;
            default: w_mbe = 4'b0000;
        endcase
    end

    assign data_mbe  = data_write ? w_mbe : 4'b0000;
    assign data_addr = {r_alu[31:2], 2'b00};

    // response-cycle data is forwarded directly so loads need no extra cycle
    assign w_raw  = w_resp ? data_rdata : r_rdata_q;
    assign w_byte = w_raw[{w_off, 3'b000} +: 8];
    assign w_half = w_raw[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        mem_rdata = w_raw;
        case (w_f3)
            c_F3_B:  mem_rdata = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: mem_rdata = {24'b0, w_byte};
            c_F3_H:  mem_rdata = {{16{w_half[15]}}, w_half};
            c_F3_HU: mem_rdata = {16'b0, w_half};
            default: mem_rdata = w_raw;
        endcase
    end

    assign MEM_alu_out     = r_alu;
    assign pc_plus4_out    = r_pc_plus4;
    assign u_imm_out       = r_u_imm;
    assign ir_out          = r_ir;
    assign rd_addr_out     = r_rd;
    assign control_rom_out = r_ctrl;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage: owns the EX/MEM latch and drives the data-memory port for loads and stores. It captures the EX results (`alu_out`, store data `rs2_out`, `rd`, control word, `pc_plus4`, `u_imm`, `ir`) and performs a single request/response handshake with data memory. While that handshake is outstanding it raises `mem_stall`. It aligns and sign- or zero-extends load data, and presents the MEM-side forwarding values (`MEM_alu_out`, `mem_rdata`) back to EX.

## Interface
Parameters: none; all widths are fixed by the rv32i types.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low. 0 clears all state immediately.
- `load`  in  1  EX/MEM latch enable, driven by the hazard/stall unit.
- `flush`  in  1  when `load`=1, latch a bubble: control word all zero, `ir` = 0.
- `alu_in`, `rs2_in`, `pc_plus4_in`, `u_imm_in`, `ir_in`  in  32 each  EX results.
- `rd_addr_in`  in  5  destination register.
- `control_rom_in`  in  `rv32i_control_word`  fields used here: `mem_read`, `mem_write`, `funct3`.
- `data_resp`  in  1  data-memory response. Single-cycle pulse.
- `data_rdata`  in  32  read data, valid only when `data_resp`=1.
- `data_read`, `data_write`  out  1 each  memory request strobes.
- `data_mbe`  out  4  store byte enables.
- `data_addr`  out  32  `{alu[31:2],2'b00}`.
- `data_wdata`  out  32  store data shifted into byte lanes.
- `mem_stall`  out  1  request outstanding and no response this cycle.
- `MEM_alu_out`, `pc_plus4_out`, `u_imm_out`, `ir_out`  out  32  latched values.
- `rd_addr_out`  out  5  latched destination register.
- `control_rom_out`  out  control word  latched control word.
- `mem_rdata`  out  32  aligned and extended load result for forwarding and WB.

## Operation
EX/MEM latch:
- On `load`=1, all input values are captured.
- On `load`=1 with `flush`=1, the control word and `ir` are captured as 0.

FSM states are IDLE, BUSY, DONE. Reset enters IDLE.
- Leaving IDLE: `load`=1 with the incoming `mem_read` or `mem_write` set goes to BUSY. `load`=1 without either goes to IDLE.
- BUSY:
  - `data_read` = latched `mem_read`; `data_write` = latched `mem_write`.
  - `data_resp`=1 → DONE, and `data_rdata` is captured into `rdata_q`.
  - If `load`=1 in the same cycle as `data_resp`, the next state is taken from the new instruction (BUSY or IDLE), not DONE.
- DONE: strobes are low. Hold until `load`=1, then decide as from IDLE.
- In BUSY, `load`=1 without `data_resp` is illegal; the hazard unit guarantees it never happens. The verifier asserts this.

Outputs:
- `mem_stall` = (state==BUSY) & ~`data_resp`. This is combinational.
- Byte offset `off` = latched `alu[1:0]`; `f3` = latched `funct3`.
- Stores:
  - sb: `mbe` = `4'b0001<<off`, `wdata` = `{4{rs2[7:0]}}`.
  - sh: `mbe` = `4'b0011<<{off[1],1'b0}`, `wdata` = `{2{rs2[15:0]}}`.
  - sw: `mbe` = `4'b1111`, `wdata` = `rs2`.
  - `mbe` = 0 whenever `data_write`=0.
- Loads: `raw` = `data_resp` ? `data_rdata` : `rdata_q`, so the value is valid in the response cycle.
  - lb / lbu: byte `raw[8*off +: 8]`, sign- or zero-extended.
  - lh / lhu: half `raw[16*off[1] +: 16]`, sign- or zero-extended.
  - lw: `raw`.
- Misaligned half- or word-accesses are not detected; the address low bits are ignored.

## Timing
- Reset values: every output is 0, the FSM is IDLE, and `rdata_q` = 0.
- An asynchronous reset in mid-handshake drops the strobes immediately. A late `data_resp` arriving afterwards is ignored.
- Request latency: strobes assert in the first cycle after the latching edge and stay high, with `addr`, `wdata` and `mbe` stable, until the `data_resp` cycle inclusive.
- Zero-wait memory (`data_resp` in the first BUSY cycle): `mem_stall` never rises; one cycle per instruction.
- N-wait memory: `mem_stall` is high for exactly N cycles.
- `mem_rdata` is valid from the response cycle and stays valid until the next `load`.
- A back-to-back memory op latched on the response edge re-enters BUSY, and its strobes assert the next cycle with no idle gap.

## Test plan
1. Reset sanity: with `reset`=0 mid-BUSY, all outputs are 0 in the same cycle. After release with `load`=1 and an ALU op, `MEM_alu_out` equals `alu_in` and strobes stay 0.
2. lw with 3-cycle-latency memory, `alu_in`=0x1004:
   - `data_addr`=0x1004, `data_read`=1 for 3 cycles.
   - `mem_stall`=1 for 2 cycles.
   - Response 0xDEADBEEF gives `mem_rdata`=0xDEADBEEF, held across extra `load`=0 cycles (DONE).
3. Load extension with `data_rdata`=0x80F0_7F81:
   - lb at off=0 → 0xFFFFFF81.
   - lbu at off=1 → 0x7F.
   - lh at off=2 → 0xFFFF80F0.
   - lhu at off=0 → 0x7F81.
4. Stores with `rs2_in`=0x11223344:
   - sb at off=3 → `mbe`=1000, `wdata`=0x44444444.
   - sh at off=2 → `mbe`=1100, `wdata`=0x33443344.
   - sw → `mbe`=1111.
5. Zero-wait back-to-back sw then lw (`data_resp` in the first BUSY cycle, `load`=1 every cycle): no `mem_stall`. `data_write` is high for one cycle and `data_read` for the next.
6. Flush: latch a lw with `flush`=1 → no strobes, `control_rom_out`=0, `ir_out`=0, FSM stays IDLE.
